// File: rtl/y86_seq_stage_controller.sv
// Sequencer for the SEQ Y86-64 core: owns the architectural PC, walks each
// instruction through FETCH..PC_UPDATE with one-hot stage enables, handshakes
// with data memory, and tracks status, retired-instruction and busy-cycle counts.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start               leave IDLE and begin fetching at pc
//   icode, ifun         fetched instruction/function codes
//   instr_invalid       fetch flagged an illegal icode/ifun
//   imem_error          fetch flagged an illegal instruction address
//   valC, valP          constant word and fall-through PC from fetch
//   valM                data returned by memory (taken with mem_ready)
//   cnd                 branch/cmov condition from execute
//   mem_ready           data memory completes the access
//   dmem_error          data memory address fault (valid with mem_ready)
//   pc                  current PC
//   fetch_en..wb_en     one-hot stage enables
//   mem_req             data memory request
//   stat                1=AOK 2=HLT 3=ADR 4=INS
//   busy                executing (not IDLE/HALTED/FAULT)
//   retired, cycles     completed instructions, clocks spent busy
module y86_seq_stage_controller #(
  parameter int unsigned      PC_W     = 64,
  parameter int unsigned      CNT_W    = 64,
  parameter logic [PC_W-1:0]  RESET_PC = '0,
  parameter logic [PC_W-1:0]  MAX_PC   = PC_W'(2400)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic             instr_invalid,
  input  logic             imem_error,
  input  logic [PC_W-1:0]  valC,
  input  logic [PC_W-1:0]  valP,
  input  logic [PC_W-1:0]  valM,
  input  logic             cnd,
  input  logic             mem_ready,
  input  logic             dmem_error,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             mem_req,
  output logic [2:0]       stat,
  output logic             busy,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PC_UPDATE,
    S_HALTED,
    S_FAULT
  } state_t;

  state_t            state, state_d;
  logic [PC_W-1:0]   pc_d;
  logic [2:0]        stat_d;
  logic              retire_inc;
  logic              cnd_q, cnd_d;
  logic [PC_W-1:0]   valm_q, valm_d;
  logic              is_mem;
  logic              unused_ifun;

  // ifun only matters to fetch/execute; the sequencer does not decode it
  assign unused_ifun = ^ifun;

  // Instructions that touch data memory: rmmovq, mrmovq, call, ret, pushq, popq
  always_comb begin
    is_mem = 1'b0;
    case (icode)
      4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: is_mem = 1'b1;
      default:                            is_mem = 1'b0;
    endcase
  end

  // Next-state, next-PC and status selection
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    stat_d     = stat;
    retire_inc = 1'b0;
    cnd_d      = cnd_q;
    valm_d     = valm_q;
    case (state)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if ((pc > MAX_PC) || imem_error) begin
          stat_d  = STAT_ADR;
          state_d = S_FAULT;
        end else if (instr_invalid) begin
          stat_d  = STAT_INS;
          state_d = S_FAULT;
        end else if (icode == I_HALT) begin
          stat_d     = STAT_HLT;
          state_d    = S_HALTED;
          retire_inc = 1'b1;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        cnd_d   = cnd;
        state_d = S_MEMORY;
      end
      S_MEMORY: begin
        if (!is_mem) begin
          state_d = S_WRITEBACK;
        end else if (mem_ready) begin
          if (dmem_error) begin
            stat_d  = STAT_ADR;
            state_d = S_FAULT;
          end else begin
            valm_d  = valM;
            state_d = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: state_d = S_PC_UPDATE;
      S_PC_UPDATE: begin
        if (icode == I_CALL)                pc_d = valC;
        else if ((icode == I_JXX) && cnd_q) pc_d = valC;
        else if (icode == I_RET)            pc_d = valm_q;
        else                                pc_d = valP;
        retire_inc = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, architectural registers and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      stat      <= STAT_AOK;
      cnd_q     <= 1'b0;
      valm_q    <= '0;
      fetch_en  <= 1'b0;
      decode_en <= 1'b0;
      exec_en   <= 1'b0;
      mem_en    <= 1'b0;
      wb_en     <= 1'b0;
      mem_req   <= 1'b0;
      busy      <= 1'b0;
      retired   <= '0;
      cycles    <= '0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      stat      <= stat_d;
      cnd_q     <= cnd_d;
      valm_q    <= valm_d;
      fetch_en  <= (state_d == S_FETCH);
      decode_en <= (state_d == S_DECODE);
      exec_en   <= (state_d == S_EXECUTE);
      mem_en    <= (state_d == S_MEMORY);
      wb_en     <= (state_d == S_WRITEBACK);
      // Held from MEMORY entry until the mem_ready cycle, which moves state_d on
      mem_req   <= (state_d == S_MEMORY) && is_mem;
      busy      <= !((state_d == S_IDLE) || (state_d == S_HALTED) ||
                     (state_d == S_FAULT));
      if (retire_inc) retired <= retired + CNT_W'(1);
      if (busy)       cycles  <= cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_y86_seq_stage_controller.sv
module tb_y86_seq_stage_controller;

  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] HLT = 3'd2;
  localparam logic [2:0] ADR = 3'd3;
  localparam logic [2:0] INS = 3'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  icode, ifun;
  logic        instr_invalid, imem_error;
  logic [63:0] valC, valP, valM;
  logic        cnd, mem_ready, dmem_error;
  logic [63:0] pc;
  logic        fetch_en, decode_en, exec_en, mem_en, wb_en, mem_req;
  logic [2:0]  stat;
  logic        busy;
  logic [63:0] retired, cycles;

  always #5 clk = ~clk;

  y86_seq_stage_controller dut (
    .clk(clk), .reset(reset), .start(start), .icode(icode), .ifun(ifun),
    .instr_invalid(instr_invalid), .imem_error(imem_error),
    .valC(valC), .valP(valP), .valM(valM), .cnd(cnd),
    .mem_ready(mem_ready), .dmem_error(dmem_error), .pc(pc),
    .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
    .mem_en(mem_en), .wb_en(wb_en), .mem_req(mem_req), .stat(stat),
    .busy(busy), .retired(retired), .cycles(cycles)
  );

  typedef struct {
    logic        restart;
    logic [3:0]  icode;
    logic        cnd;
    logic        inv;
    logic        imerr;
    logic        derr;
    int          wait_n;
    logic [63:0] valc, valp, valm;
    logic [63:0] exp_pc;
    int          exp_lat;
    int          exp_mreq;
    logic [2:0]  exp_stat;
    logic        exp_wb;
    logic        exp_retire;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    int          lat;
    int          mreq;
    logic [2:0]  stat;
    logic        wb;
    logic [63:0] retired;
    logic [63:0] cycles;
  } exp_t;

  vec_t        tbl[16];
  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_retired = 0;
  logic [63:0] exp_cycles  = 0;

  function automatic vec_t mk(logic rs, logic [3:0] ic, logic c, logic inv,
                              logic ime, logic de, int w, logic [63:0] vc,
                              logic [63:0] vp, logic [63:0] vm, logic [63:0] epc,
                              int lat, int mr, logic [2:0] st, logic wb, logic rt);
    vec_t v;
    v.restart = rs; v.icode = ic; v.cnd = c; v.inv = inv; v.imerr = ime;
    v.derr = de; v.wait_n = w; v.valc = vc; v.valp = vp; v.valm = vm;
    v.exp_pc = epc; v.exp_lat = lat; v.exp_mreq = mr; v.exp_stat = st;
    v.exp_wb = wb; v.exp_retire = rt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    start = 0; icode = 0; ifun = 0; instr_invalid = 0; imem_error = 0;
    valC = 0; valP = 0; valM = 0; cnd = 0; mem_ready = 0; dmem_error = 0;
  endtask

  // Reset (checked while held), then start; leaves DUT in FETCH at #1 after an edge
  task automatic restart();
    clear_inputs();
    reset = 1;
    #1;
    chk("rst_pc", pc, 64'd0);
    chk("rst_stat", 64'(stat), 64'(AOK));
    chk("rst_en", 64'({fetch_en, decode_en, exec_en, mem_en, wb_en, mem_req, busy}), 64'd0);
    chk("rst_cnt", retired | cycles, 64'd0);
    @(negedge clk);
    reset = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("start_fetch", 64'(fetch_en), 64'd1);
    exp_retired = 0;
    exp_cycles  = 0;
  endtask

  // Apply one instruction from FETCH until next FETCH or a terminal state
  task automatic run_vec(input vec_t r, input int idx);
    exp_t e, got;
    int   mcnt;
    logic done;
    if (r.restart) restart();
    exp_retired += 64'(r.exp_retire);
    exp_cycles  += 64'(r.exp_lat);
    e.pc = r.exp_pc; e.lat = r.exp_lat; e.mreq = r.exp_mreq; e.stat = r.exp_stat;
    e.wb = r.exp_wb; e.retired = exp_retired; e.cycles = exp_cycles;
    sbq.push_back(e);
    icode = r.icode; ifun = 4'h0; instr_invalid = r.inv; imem_error = r.imerr;
    valC = r.valc; valP = r.valp;
    got.lat = 0; got.mreq = 0; got.wb = 0; mcnt = 0; done = 0;
    for (int c = 0; c < 64; c++) begin
      if (mem_req) mcnt++;
      mem_ready  = mem_req && (mcnt >= r.wait_n);
      dmem_error = mem_ready && r.derr;
      valM       = mem_ready ? r.valm : 64'hdead_beef;
      cnd        = exec_en ? r.cnd : !r.cnd;
      @(posedge clk); #1;
      got.lat++;
      if (mem_req) got.mreq++;
      if (wb_en) got.wb = 1;
      if (fetch_en || !busy) begin
        done = 1;
        break;
      end
    end
    mem_ready = 0; dmem_error = 0;
    got.pc = pc; got.stat = stat; got.retired = retired; got.cycles = cycles;
    e = sbq.pop_front();
    if (!done) begin
      errors++;
      $display("FAIL vec%0d_timeout no completion within 64 cycles", idx);
    end
    chk($sformatf("vec%0d_pc", idx), got.pc, e.pc);
    chk($sformatf("vec%0d_lat", idx), 64'(got.lat), 64'(e.lat));
    chk($sformatf("vec%0d_mreq", idx), 64'(got.mreq), 64'(e.mreq));
    chk($sformatf("vec%0d_stat", idx), 64'(got.stat), 64'(e.stat));
    chk($sformatf("vec%0d_wb", idx), 64'(got.wb), 64'(e.wb));
    chk($sformatf("vec%0d_busy", idx), 64'(busy), 64'(e.stat == AOK));
    chk($sformatf("vec%0d_retired", idx), got.retired, e.retired);
    chk($sformatf("vec%0d_cycles", idx), got.cycles, e.cycles);
  endtask

  initial begin
    logic found;
    reset = 1;
    clear_inputs();
    //              rs ic  c inv ime de w  valC      valP                  valM     exp_pc                lat mr stat wb rt
    tbl[0]  = mk(1, 4'h1, 0, 0, 0, 0, 0, 64'h0,    64'h1,                64'h0,   64'h1,                6, 0, AOK, 1, 1);
    tbl[1]  = mk(0, 4'h7, 1, 0, 0, 0, 0, 64'h40,   64'h10,               64'h0,   64'h40,               6, 0, AOK, 1, 1);
    tbl[2]  = mk(0, 4'h7, 0, 0, 0, 0, 0, 64'h80,   64'h9,                64'h0,   64'h9,                6, 0, AOK, 1, 1);
    tbl[3]  = mk(0, 4'h5, 0, 0, 0, 0, 3, 64'h0,    64'h13,               64'h77,  64'h13,               8, 3, AOK, 1, 1);
    tbl[4]  = mk(0, 4'h9, 0, 0, 0, 0, 1, 64'h999,  64'h14,               64'h100, 64'h100,              6, 1, AOK, 1, 1);
    tbl[5]  = mk(0, 4'h8, 0, 0, 0, 0, 2, 64'h200,  64'h10a,              64'h0,   64'h200,              7, 2, AOK, 1, 1);
    tbl[6]  = mk(0, 4'h2, 1, 0, 0, 0, 0, 64'h500,  64'h102,              64'h0,   64'h102,              6, 0, AOK, 1, 1);
    tbl[7]  = mk(0, 4'h0, 0, 0, 0, 0, 0, 64'h0,    64'h103,              64'h0,   64'h102,              1, 0, HLT, 0, 1);
    tbl[8]  = mk(1, 4'h1, 0, 1, 0, 0, 0, 64'h0,    64'h1,                64'h0,   64'h0,                1, 0, INS, 0, 0);
    tbl[9]  = mk(1, 4'h5, 0, 0, 0, 1, 2, 64'h0,    64'h3,                64'h0,   64'h0,                5, 2, ADR, 0, 0);
    tbl[10] = mk(1, 4'h7, 1, 0, 0, 0, 0, 64'd2400, 64'h2,                64'h0,   64'd2400,             6, 0, AOK, 1, 1);
    tbl[11] = mk(0, 4'h1, 0, 0, 0, 0, 0, 64'h0,    64'd2401,             64'h0,   64'd2401,             6, 0, AOK, 1, 1);
    tbl[12] = mk(0, 4'h1, 0, 0, 0, 0, 0, 64'h0,    64'd2402,             64'h0,   64'd2401,             1, 0, ADR, 0, 0);
    tbl[13] = mk(1, 4'h1, 0, 1, 1, 0, 0, 64'h0,    64'h1,                64'h0,   64'h0,                1, 0, ADR, 0, 0);
    tbl[14] = mk(1, 4'h6, 0, 0, 0, 0, 0, 64'h0,    64'hffff_ffff_ffff_ffff, 64'h0, 64'hffff_ffff_ffff_ffff, 6, 0, AOK, 1, 1);
    tbl[15] = mk(0, 4'h1, 0, 0, 0, 0, 0, 64'h0,    64'h0,                64'h0,   64'hffff_ffff_ffff_ffff, 1, 0, ADR, 0, 0);

    for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

    // HALTED is sticky: start is ignored and cycles stops counting
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (3) begin @(posedge clk); #1; end
    chk("halt_fetch", 64'(fetch_en), 64'd0);
    chk("halt_busy", 64'(busy), 64'd0);
    chk("halt_stat", 64'(stat), 64'(HLT));
    chk("halt_pc", pc, 64'h102);
    chk("halt_cycles", cycles, 64'd46);
    chk("halt_retired", retired, 64'd8);

    for (int i = 8; i < 16; i++) run_vec(tbl[i], i);

    // Asynchronous reset in the middle of a stalled memory access
    restart();
    icode = 4'h4; valP = 64'h30;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (mem_req) begin found = 1; break; end
    end
    chk("amid_memreq", 64'(found), 64'd1);
    @(posedge clk); #1;
    chk("amid_memreq_held", 64'(mem_req), 64'd1);
    #2;
    reset = 1;
    #1;
    chk("amid_memreq_drop", 64'(mem_req), 64'd0);
    chk("amid_pc", pc, 64'd0);
    chk("amid_enables", 64'({fetch_en, decode_en, exec_en, mem_en, wb_en, busy}), 64'd0);
    chk("amid_cycles", cycles, 64'd0);
    @(negedge clk);
    reset = 0;
    clear_inputs();
    start = 1;
    @(posedge clk); #1;
    start = 0;
    exp_retired = 0;
    exp_cycles  = 0;
    run_vec(mk(0, 4'h1, 0, 0, 0, 0, 0, 64'h0, 64'h5, 64'h0, 64'h5, 6, 0, AOK, 1, 1), 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
